// File: rtl/bp_pkg.sv
// Shared branch-predictor types: PHT index type and 2-bit saturating counter encoding.
package bp_pkg;

  localparam int unsigned IdxWidth = 12;

  typedef logic [IdxWidth-1:0] idx_t;

  typedef enum logic [1:0] {
    CtrStrongNt = 2'b00,
    CtrWeakNt   = 2'b01,
    CtrWeakT    = 2'b10,
    CtrStrongT  = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
    unique case (ctr)
      CtrStrongNt: ctr_next = taken ? CtrWeakNt  : CtrStrongNt;
      CtrWeakNt:   ctr_next = taken ? CtrWeakT   : CtrStrongNt;
      CtrWeakT:    ctr_next = taken ? CtrStrongT : CtrWeakNt;
      default:     ctr_next = taken ? CtrStrongT : CtrWeakT;
    endcase
  endfunction

endpackage

// File: rtl/bp_idx_fifo.sv
// Synchronous FIFO of PHT indices for in-flight branches; clear wins over push.
module bp_idx_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ghr_index_gen.sv
// Global history and PHT index generation with in-flight index tracking.
// Define GHR_PC_XOR_EN for gshare indexing (PC ^ GHR); default is GAg (GHR only).
module ghr_index_gen
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = IdxWidth,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fetch_valid_i,
  input  logic                   fetch_is_br_i,
  input  logic [31:0]            fetch_pc_i,
  input  logic                   pred_taken_i,
  output logic [INDEX_WIDTH-1:0] rd_index_o,
  output logic                   stall_o,
  input  logic                   res_valid_i,
  input  logic                   res_taken_i,
  input  logic                   res_mispredict_i,
  input  logic                   flush_i,
  output logic                   update_en_o,
  output logic [INDEX_WIDTH-1:0] update_index_o,
  output logic                   br_taken_o
);

  logic [INDEX_WIDTH-1:0] spec_ghr_q, spec_ghr_d;
  logic [INDEX_WIDTH-1:0] commit_ghr_q, commit_ghr_d;
  logic [INDEX_WIDTH-1:0] fifo_head;
  logic                   fifo_full, fifo_empty;
  logic                   resolve, mispredict, push;

`ifdef GHR_PC_XOR_EN
  logic unused_pc;
  assign unused_pc  = ^{fetch_pc_i[31:INDEX_WIDTH+2], fetch_pc_i[1:0]};
  assign rd_index_o = fetch_pc_i[INDEX_WIDTH+1:2] ^ spec_ghr_q;
`else
  logic unused_pc;
  assign unused_pc  = ^fetch_pc_i;
  assign rd_index_o = spec_ghr_q;
`endif

  assign resolve    = res_valid_i & ~fifo_empty;
  assign mispredict = resolve & res_mispredict_i;
  // A resolving pop frees a slot this cycle, so a full FIFO can still accept.
  assign push = fetch_valid_i & fetch_is_br_i & (~fifo_full | resolve) & ~flush_i & ~mispredict;

  assign stall_o        = fifo_full;
  assign update_en_o    = resolve;
  assign update_index_o = fifo_head;
  assign br_taken_o     = res_taken_i;

  always_comb begin
    commit_ghr_d = commit_ghr_q;
    if (resolve) commit_ghr_d = {commit_ghr_q[INDEX_WIDTH-2:0], res_taken_i};

    spec_ghr_d = spec_ghr_q;
    if (mispredict || flush_i) begin
      spec_ghr_d = commit_ghr_d;
    end else if (push) begin
      spec_ghr_d = {spec_ghr_q[INDEX_WIDTH-2:0], pred_taken_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spec_ghr_q   <= '0;
      commit_ghr_q <= '0;
    end else begin
      spec_ghr_q   <= spec_ghr_d;
      commit_ghr_q <= commit_ghr_d;
    end
  end

  bp_idx_fifo #(
    .Width (INDEX_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (resolve),
    .clear_i (flush_i | mispredict),
    .data_i  (rd_index_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_ghr_index_gen.sv
// Table-driven bench for ghr_index_gen with a scoreboard of in-flight PHT indices.
module tb_ghr_index_gen;

  localparam int unsigned W = 12;
  localparam int unsigned D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         fetch_valid, fetch_is_br, pred_taken;
  logic [31:0]  fetch_pc;
  logic [W-1:0] rd_index;
  logic         stall;
  logic         res_valid, res_taken, res_mispredict, flush;
  logic         update_en;
  logic [W-1:0] update_index;
  logic         br_taken;

  ghr_index_gen #(
    .INDEX_WIDTH (W),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .fetch_valid_i    (fetch_valid),
    .fetch_is_br_i    (fetch_is_br),
    .fetch_pc_i       (fetch_pc),
    .pred_taken_i     (pred_taken),
    .rd_index_o       (rd_index),
    .stall_o          (stall),
    .res_valid_i      (res_valid),
    .res_taken_i      (res_taken),
    .res_mispredict_i (res_mispredict),
    .flush_i          (flush),
    .update_en_o      (update_en),
    .update_index_o   (update_index),
    .br_taken_o       (br_taken)
  );

  always #5 clk = ~clk;

  // exp_ghr is the speculative history expected while the row is applied.
  typedef struct {
    logic         rst, fv, br, pred, rv, rt, rm, fl;
    logic [W-1:0] exp_ghr;
    logic         exp_stall, exp_upd;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] sb_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic add(input logic r, fv, br, pred, rv, rt, rm, fl,
                     input logic [W-1:0] g, input logic st, up);
    vec_t v;
    v.rst = r;  v.fv = fv; v.br = br; v.pred = pred;
    v.rv  = rv; v.rt = rt; v.rm = rm; v.fl   = fl;
    v.exp_ghr = g; v.exp_stall = st; v.exp_upd = up;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [W-1:0] g, input logic [31:0] pc);
    logic [W-1:0] pc_bits;
    pc_bits = pc[W+1:2];
`ifdef GHR_PC_XOR_EN
    return g ^ pc_bits;
`else
    return g | (pc_bits & '0);
`endif
  endfunction

  initial begin
    logic [W-1:0] g;

    // Fill/resolve basics, commit history observed through a later flush.
    add(0,1,1,1, 0,0,0,0, 12'h000, 0, 0);
    add(0,1,1,0, 0,0,0,0, 12'h001, 0, 0);
    add(0,1,1,1, 0,0,0,0, 12'h002, 0, 0);
    add(0,0,0,0, 1,1,0,0, 12'h005, 0, 1);
    add(0,0,0,0, 0,0,0,1, 12'h005, 0, 0);
    add(0,0,0,0, 0,0,0,0, 12'h001, 0, 0);
    // Resolve on empty FIFO is ignored.
    add(0,0,0,0, 1,1,0,0, 12'h001, 0, 0);
    add(0,0,0,0, 0,0,0,1, 12'h001, 0, 0);
    add(0,0,0,0, 0,0,0,0, 12'h001, 0, 0);
    // Build commit=0x005, spec=0x05B, then mispredict with a same-cycle push.
    add(0,1,1,0, 0,0,0,0, 12'h001, 0, 0);
    add(0,1,1,1, 0,0,0,0, 12'h002, 0, 0);
    add(0,0,0,0, 1,0,0,0, 12'h005, 0, 1);
    add(0,0,0,0, 1,1,0,0, 12'h005, 0, 1);
    add(0,1,1,1, 0,0,0,0, 12'h005, 0, 0);
    add(0,1,1,0, 0,0,0,0, 12'h00B, 0, 0);
    add(0,1,1,1, 0,0,0,0, 12'h016, 0, 0);
    add(0,1,1,1, 0,0,0,0, 12'h02D, 0, 0);
    add(0,1,1,1, 1,0,1,0, 12'h05B, 0, 1);
    add(0,0,0,0, 1,1,0,0, 12'h00A, 0, 0);
    // Reset mid-stream, then commit=0x003 and flush with a same-cycle resolve.
    add(1,1,1,1, 1,1,0,0, 12'h000, 0, 0);
    add(0,0,0,0, 0,0,0,0, 12'h000, 0, 0);
    add(0,1,1,1, 0,0,0,0, 12'h000, 0, 0);
    add(0,1,1,1, 0,0,0,0, 12'h001, 0, 0);
    add(0,1,1,0, 0,0,0,0, 12'h003, 0, 0);
    add(0,0,0,0, 1,1,0,0, 12'h006, 0, 1);
    add(0,0,0,0, 1,1,0,0, 12'h006, 0, 1);
    add(0,1,1,1, 1,1,0,1, 12'h006, 0, 1);
    add(0,0,0,0, 0,0,0,0, 12'h007, 0, 0);
    add(0,0,0,0, 1,1,0,0, 12'h007, 0, 0);
    // Fill to full, push while stalled, then push+resolve while full.
    for (int k = 0; k < 8; k++) begin
      g = (W'(8) << k) - W'(1);
      add(0,1,1,1, 0,0,0,0, g, 0, 0);
    end
    add(0,1,1,0, 0,0,0,0, 12'h7FF, 1, 0);
    add(0,1,1,0, 1,1,0,0, 12'h7FF, 1, 1);
    add(0,0,0,0, 0,0,0,0, 12'hFFE, 1, 0);
    add(0,0,0,0, 0,0,0,1, 12'hFFE, 1, 0);
    add(0,0,0,0, 0,0,0,0, 12'h00F, 0, 0);

    rst = 1'b1;
    fetch_valid = 1'b0; fetch_is_br = 1'b0; pred_taken = 1'b0; fetch_pc = 32'h0;
    res_valid = 1'b0; res_taken = 1'b0; res_mispredict = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_index", rd_index, '0);
    chk("reset_stall", stall, 1'b0);
    chk("reset_update_en", update_en, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t        v;
      logic [31:0] pc;
      logic        res_m, mis, acc;
      v  = vecs[i];
      pc = 32'h40 + i * 32'h104;
      @(posedge clk);
      #1;
      rst = v.rst; fetch_valid = v.fv; fetch_is_br = v.br; pred_taken = v.pred;
      fetch_pc = pc; res_valid = v.rv; res_taken = v.rt; res_mispredict = v.rm; flush = v.fl;
      @(negedge clk);
      chk($sformatf("rd_index[%0d]", i), rd_index, exp_rd(v.exp_ghr, pc));
      chk($sformatf("stall[%0d]", i), stall, v.exp_stall);
      chk($sformatf("update_en[%0d]", i), update_en, v.exp_upd);
      chk($sformatf("br_taken[%0d]", i), br_taken, v.rt);
      if (v.rst) begin
        sb_q.delete();
      end else begin
        res_m = v.rv && (sb_q.size() != 0);
        mis   = res_m && v.rm;
        acc   = v.fv && v.br && ((sb_q.size() < D) || res_m) && !v.fl && !mis;
        if (res_m) chk($sformatf("update_index[%0d]", i), update_index, sb_q.pop_front());
        if (v.fl || mis) sb_q.delete();
        if (acc) sb_q.push_back(exp_rd(v.exp_ghr, pc));
      end
    end

    @(posedge clk);
    #1;
    rst = 1'b0; fetch_valid = 1'b0; fetch_is_br = 1'b0; res_valid = 1'b0; flush = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
